// File: rtl/rr_decoder_arbiter_if.sv
// Requester/decoder-side bundle for the round-robin decoder arbiter.
// The arbiter uses the slave view; the requester side uses the master view.
interface rr_decoder_arbiter_if;
  logic [7:0] req;
  logic [2:0] sel;
  logic       sel_en_n;
  logic [7:0] grant_n;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    input  sel, sel_en_n, grant_n, busy, timeout
  );

  modport slave (
    input  req,
    output sel, sel_en_n, grant_n, busy, timeout
  );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 active-low decoder among 8 requesters,
// with a per-grant hold limit and a guard gap between consecutive grants.
module rr_decoder_arbiter #(
  parameter int HOLD_MAX     = 16,
  parameter int GUARD_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_decoder_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_MAX - 1);
  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [2:0] sel_reg, sel_next;
  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic [3:0] guard_cnt_reg, guard_cnt_next;
  logic       sel_en_n_reg, sel_en_n_next;
  logic [7:0] grant_n_reg, grant_n_next;
  logic       busy_reg, busy_next;
  logic       timeout_reg, timeout_next;
  logic       forced_release;

  logic [7:0] req_rot;
  logic [2:0] offset;
  logic       found;
  logic [2:0] winner;

  // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign req_rot[gi] = bus.req[ptr_reg + 3'(gi)];
    end
  endgenerate

  always_comb begin
    offset = 3'd0;
    found  = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) begin
        offset = 3'(k);
        found  = 1'b1;
      end
    end
  end

  assign winner = ptr_reg + offset;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= 3'd0;
      sel_reg       <= 3'd0;
      hold_cnt_reg  <= 8'd0;
      guard_cnt_reg <= 4'd0;
      sel_en_n_reg  <= 1'b1;
      grant_n_reg   <= 8'hFF;
      busy_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      sel_reg       <= sel_next;
      hold_cnt_reg  <= hold_cnt_next;
      guard_cnt_reg <= guard_cnt_next;
      sel_en_n_reg  <= sel_en_n_next;
      grant_n_reg   <= grant_n_next;
      busy_reg      <= busy_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    sel_next       = sel_reg;
    hold_cnt_next  = hold_cnt_reg;
    guard_cnt_next = guard_cnt_reg;
    forced_release = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (found) begin
          state_next    = GRANT;
          sel_next      = winner;
          hold_cnt_next = 8'd0;
        end
      end
      GRANT: begin
        // A dropped request beats the hold limit, so timeout stays low then.
        if (!bus.req[sel_reg] || (hold_cnt_reg == HOLD_LAST)) begin
          forced_release = bus.req[sel_reg];
          ptr_next       = sel_reg + 3'd1;
          guard_cnt_next = 4'd0;
          state_next     = (GUARD_CYCLES > 0) ? GUARD : IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg + 8'd1;
        end
      end
      GUARD: begin
        if (guard_cnt_reg == GUARD_LAST) begin
          state_next = IDLE;
        end else begin
          guard_cnt_next = guard_cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_en_n_next = (state_next != GRANT);
    grant_n_next  = sel_en_n_next ? 8'hFF : ~(8'b1 << sel_next);
    busy_next     = (state_next != IDLE);
    timeout_next  = forced_release;
  end

  assign bus.sel      = sel_reg;
  assign bus.sel_en_n = sel_en_n_reg;
  assign bus.grant_n  = grant_n_reg;
  assign bus.busy     = busy_reg;
  assign bus.timeout  = timeout_reg;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench: instance a uses HOLD_MAX=16, instance b uses HOLD_MAX=4; both GUARD_CYCLES=1.
module tb_rr_decoder_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rr_decoder_arbiter_if bus_a ();
  rr_decoder_arbiter_if bus_b ();

  rr_decoder_arbiter #(.HOLD_MAX(16), .GUARD_CYCLES(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  rr_decoder_arbiter #(.HOLD_MAX(4), .GUARD_CYCLES(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, ".grant_n"}, 32'(bus_a.grant_n), 32'hFF);
    chk({tag, ".sel_en_n"}, 32'(bus_a.sel_en_n), 32'd1);
    chk({tag, ".busy"}, 32'(bus_a.busy), 32'd0);
    chk({tag, ".timeout"}, 32'(bus_a.timeout), 32'd0);
    chk({tag, ".sel"}, 32'(bus_a.sel), 32'd0);
  endtask

  initial begin
    logic [2:0]  exp_idx;
    logic [7:0]  exp_gn;

    // 1. reset held 3 cycles with all requests asserted
    rst_n = 1'b0;
    bus_a.req = 8'hFF;
    bus_b.req = 8'hFF;
    @(negedge clk);
    repeat (3) tick();
    chk_idle_a("rst_a");
    chk("rst_b.grant_n", 32'(bus_b.grant_n), 32'hFF);
    chk("rst_b.busy", 32'(bus_b.busy), 32'd0);
    rst_n = 1'b1;
    bus_a.req = 8'h00;
    bus_b.req = 8'h00;
    tick();
    chk("idle_a.busy", 32'(bus_a.busy), 32'd0);

    // 2. single requester 3, voluntary release after 5 cycles, 1-cycle guard
    bus_a.req = 8'h08;
    tick();
    chk("t2.sel", 32'(bus_a.sel), 32'd3);
    chk("t2.grant_n", 32'(bus_a.grant_n), 32'hF7);
    chk("t2.sel_en_n", 32'(bus_a.sel_en_n), 32'd0);
    chk("t2.busy", 32'(bus_a.busy), 32'd1);
    repeat (4) tick();
    chk("t2.hold_gn", 32'(bus_a.grant_n), 32'hF7);
    bus_a.req = 8'h00;
    tick();
    chk("t2.rel_gn", 32'(bus_a.grant_n), 32'hFF);
    chk("t2.rel_en_n", 32'(bus_a.sel_en_n), 32'd1);
    chk("t2.guard_busy", 32'(bus_a.busy), 32'd1);
    chk("t2.rel_tmo", 32'(bus_a.timeout), 32'd0);
    chk("t2.rel_sel", 32'(bus_a.sel), 32'd3);
    tick();
    chk("t2.idle_busy", 32'(bus_a.busy), 32'd0);
    chk("t2.idle_gn", 32'(bus_a.grant_n), 32'hFF);

    // 3/4. HOLD_MAX=4, req 0 and 7 held: forced grants alternate 0,7,0,7 (7->0 wraps)
    bus_b.req = 8'h81;
    for (int g = 0; g < 4; g++) begin
      exp_idx = (g % 2 == 1) ? 3'd7 : 3'd0;
      exp_gn  = ~(8'b1 << exp_idx);
      tick();
      chk($sformatf("t3.g%0d.gn0", g), 32'(bus_b.grant_n), 32'(exp_gn));
      chk($sformatf("t3.g%0d.sel", g), 32'(bus_b.sel), 32'(exp_idx));
      for (int c = 1; c < 4; c++) begin
        tick();
        chk($sformatf("t3.g%0d.gn%0d", g, c), 32'(bus_b.grant_n), 32'(exp_gn));
        chk($sformatf("t3.g%0d.tmo%0d", g, c), 32'(bus_b.timeout), 32'd0);
      end
      tick();
      chk($sformatf("t3.g%0d.rel_gn", g), 32'(bus_b.grant_n), 32'hFF);
      chk($sformatf("t3.g%0d.tmo", g), 32'(bus_b.timeout), 32'd1);
      chk($sformatf("t3.g%0d.busy", g), 32'(bus_b.busy), 32'd1);
      tick();
      chk($sformatf("t3.g%0d.gap_gn", g), 32'(bus_b.grant_n), 32'hFF);
      chk($sformatf("t3.g%0d.tmo_off", g), 32'(bus_b.timeout), 32'd0);
      chk($sformatf("t3.g%0d.idle", g), 32'(bus_b.busy), 32'd0);
    end

    // 5. req[0] drops exactly when the hold limit is reached: voluntary, no timeout
    tick();
    chk("t5.gn", 32'(bus_b.grant_n), 32'hFE);
    repeat (3) tick();
    chk("t5.gn_last", 32'(bus_b.grant_n), 32'hFE);
    bus_b.req = 8'h80;
    tick();
    chk("t5.rel_gn", 32'(bus_b.grant_n), 32'hFF);
    chk("t5.tmo", 32'(bus_b.timeout), 32'd0);
    tick();
    chk("t5.idle", 32'(bus_b.busy), 32'd0);
    tick();
    chk("t5.next_gn", 32'(bus_b.grant_n), 32'h7F);

    // 6. reset mid-grant of requester 5 (ptr was 4 in instance a), then req 0 and 5
    bus_a.req = 8'h20;
    tick();
    chk("t6.gn5", 32'(bus_a.grant_n), 32'hDF);
    chk("t6.sel5", 32'(bus_a.sel), 32'd5);
    tick();
    chk("t6.gn5_hold", 32'(bus_a.grant_n), 32'hDF);
    rst_n = 1'b0;
    bus_a.req = 8'h21;
    bus_b.req = 8'h00;
    tick();
    chk_idle_a("t6.rst");
    chk("t6.rst_b_gn", 32'(bus_b.grant_n), 32'hFF);
    chk("t6.rst_b_busy", 32'(bus_b.busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t6.post_gn", 32'(bus_a.grant_n), 32'hFE);
    chk("t6.post_sel", 32'(bus_a.sel), 32'd0);
    chk("t6.post_busy", 32'(bus_a.busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
